// File: rtl/am25ls377_ldarb.sv
// am25ls377_ldarb: arbitrates four requesters onto one shared bus feeding four
// enable-loaded octal registers. Define AM25LS377_LDARB_RR_EN for round-robin, else fixed priority.
`default_nettype none

module am25ls377_ldarb #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic [3:0]         req,
    input  logic [7:0]         addr,
    input  logic [4*WIDTH-1:0] din,
    output logic [WIDTH-1:0]   d,
    output logic [3:0]         e_,
    output logic [3:0]         ack,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [3:0]       e_q, e_d;
    logic [3:0]       ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       win_idx;
    logic             win_valid;

`ifdef AM25LS377_LDARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;

    // Scan farthest-first so the index closest to the pointer overrides.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_IDLE && win_valid) begin
            ptr_d = win_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                win_valid = 1'b1;
                win_idx   = 2'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        e_d     = 4'b1111;
        ack_d   = 4'b0000;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d = S_LOAD;
                    d_d     = din[WIDTH*win_idx +: WIDTH];
                    e_d     = ~(4'b0001 << addr[2*win_idx +: 2]);
                    grant_d = win_idx;
                end
            end
            S_LOAD: begin
                state_d = S_ACK;
                ack_d   = 4'b0001 << grant_q;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            e_q     <= 4'b1111;
            ack_q   <= 4'b0000;
            busy_q  <= 1'b0;
            grant_q <= 2'd0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            e_q     <= e_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
        end
    end

    assign d    = d_q;
    assign e_   = e_q;
    assign ack  = ack_q;
    assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_am25ls377_ldarb.sv
// Scoreboard bench for am25ls377_ldarb with a behavioural model of the four-register bank.
`default_nettype none

module tb_am25ls377_ldarb;

    localparam int WIDTH = 8;

    logic               clk  = 1'b0;
    logic               rst_ = 1'b1;
    logic [3:0]         req  = 4'b0000;
    logic [7:0]         addr = 8'h00;
    logic [4*WIDTH-1:0] din  = '0;
    logic [WIDTH-1:0]   d;
    logic [3:0]         e_;
    logic [3:0]         ack;
    logic               busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] ack;
        logic [3:0] en;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] bank [4];
    logic [7:0] snap [4];

    am25ls377_ldarb #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .req  (req),
        .addr (addr),
        .din  (din),
        .d    (d),
        .e_   (e_),
        .ack  (ack),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Four octal registers with active-low load enables sharing bus d.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!e_[i]) bank[i] <= d;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || busy) && n < 200);
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got timeout expected idle with %0d pending", sb.size());
        end
    endtask

    // Monitor: checks every transaction against the scoreboard and plays the requester's ack-drop.
    initial begin
        logic       load_seen;
        logic [3:0] le;
        logic [7:0] ld;
        exp_t       x;
        load_seen = 1'b0;
        le        = 4'b1111;
        ld        = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_) begin
                load_seen = 1'b0;
                continue;
            end
            chk("e_onehot0", 32'($countones(~e_) <= 1), 32'd1);
            chk("ack_onehot0", 32'($countones(ack) <= 1), 32'd1);
            if (ack != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (ack[i]) req[i] = 1'b0;
                end
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got %b expected none", ack);
                end else begin
                    x = sb.pop_front();
                    chk("ack", 32'(ack), 32'(x.ack));
                    chk("ack_d", 32'(d), 32'(x.data));
                    chk("ack_e_high", 32'(e_), 32'hF);
                    chk("load_latency", 32'(load_seen), 32'd1);
                    chk("load_e", 32'(le), 32'(x.en));
                    chk("load_d", 32'(ld), 32'(x.data));
                end
            end
            load_seen = (e_ != 4'b1111);
            if (load_seen) begin
                le = e_;
                ld = d;
            end
        end
    end

    initial begin
        #1 rst_ = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_e", 32'(e_), 32'hF);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_d", 32'(d), 32'h0);
        rst_ = 1'b1;

        // All four requesters at once, all targeting register 0.
        addr = 8'h00;
        din  = {8'h40, 8'h30, 8'h20, 8'h10};
        sb.push_back('{4'b0001, 4'b1110, 8'h10});
        sb.push_back('{4'b0010, 4'b1110, 8'h20});
        sb.push_back('{4'b0100, 4'b1110, 8'h30});
        sb.push_back('{4'b1000, 4'b1110, 8'h40});
        req = 4'b1111;
        wait_idle();
        chk("all4_bank0", 32'(bank[0]), 32'h40);

        // req0 and req3 together: requester 0 goes first in either mode here.
        addr = {2'd3, 2'd0, 2'd0, 2'd1};
        din  = {8'hE1, 8'h00, 8'h00, 8'h5A};
        sb.push_back('{4'b0001, 4'b1101, 8'h5A});
        sb.push_back('{4'b1000, 4'b0111, 8'hE1});
        req = 4'b1001;
        wait_idle();
        chk("r03_bank1", 32'(bank[1]), 32'h5A);
        chk("r03_bank3", 32'(bank[3]), 32'hE1);

        // Single request, explicit cycle-by-cycle latency.
        addr = 8'h02;
        din  = {8'h00, 8'h00, 8'h00, 8'hA5};
        sb.push_back('{4'b0001, 4'b1011, 8'hA5});
        req = 4'b0001;
        @(negedge clk);
        chk("single_load_e", 32'(e_), 32'hB);
        chk("single_load_d", 32'(d), 32'hA5);
        @(negedge clk);
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_ack_e", 32'(e_), 32'hF);
        wait_idle();
        chk("single_bank2", 32'(bank[2]), 32'hA5);

        // Arbitration-mode dependent order.
        addr = {2'd0, 2'd0, 2'd1, 2'd0};
        din  = {8'h00, 8'h00, 8'hC3, 8'h3C};
`ifdef AM25LS377_LDARB_RR_EN
        sb.push_back('{4'b0010, 4'b1101, 8'hC3});
        sb.push_back('{4'b0001, 4'b1110, 8'h3C});
`else
        sb.push_back('{4'b0001, 4'b1110, 8'h3C});
        sb.push_back('{4'b0010, 4'b1101, 8'hC3});
`endif
        req = 4'b0011;
        wait_idle();
        chk("r01_bank0", 32'(bank[0]), 32'h3C);
        chk("r01_bank1", 32'(bank[1]), 32'hC3);

        // Hold with no requests.
        for (int i = 0; i < 4; i++) snap[i] = bank[i];
        req = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_e", 32'(e_), 32'hF);
            chk("hold_ack", 32'(ack), 32'h0);
            chk("hold_busy", 32'(busy), 32'h0);
        end
        for (int i = 0; i < 4; i++) chk("hold_bank", 32'(bank[i]), 32'(snap[i]));

        // Same target after a fresh reset: later write wins.
        rst_ = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        addr = {2'd0, 2'd0, 2'd3, 2'd3};
        din  = {8'h00, 8'h00, 8'h22, 8'h11};
        sb.push_back('{4'b0001, 4'b0111, 8'h11});
        sb.push_back('{4'b0010, 4'b0111, 8'h22});
        req = 4'b0011;
        wait_idle();
        chk("same_bank3", 32'(bank[3]), 32'h22);

        // Reset in the middle of a load.
        addr = {2'd0, 2'd0, 2'd2, 2'd0};
        din  = {8'h00, 8'h00, 8'h99, 8'h77};
        sb.push_back('{4'b0010, 4'b1011, 8'h99});
        req = 4'b0011;
        @(negedge clk);
        chk("pre_abort_e", 32'(e_), 32'hE);
        #2;
        rst_ = 1'b0;
        req  = 4'b0010;
        #1;
        chk("abort_e", 32'(e_), 32'hF);
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_d", 32'(d), 32'h0);
        @(negedge clk);
        rst_ = 1'b1;
        wait_idle();
        chk("abort_bank0", 32'(bank[0]), 32'h3C);
        chk("abort_bank2", 32'(bank[2]), 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
